modbus_crc_sequencer: RTL and testbench
=======================================

# modbus_crc_sequencer

Sequences the shared `Modbus_CRC16` byte engine over whole Modbus RTU frames. It arbitrates between the RX path (frame check) and the TX path (CRC generation). It reads frame bytes from the RX/TX frame buffers, feeds them one at a time to the engine, and returns a per-frame result. It sits between the UART framing logic and the single CRC engine instance in the controller top.

## Interface
Parameters:
- `ADDR_W`, default 8: frame-buffer address width; max frame length 2^ADDR_W bytes.
- `TIMEOUT`, default 31: cycles allowed from `o_crc_start` to `i_crc_done` before error.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_rx_req`  in  1  RX check request; level, held until `o_rx_done`.
- `i_rx_len`  in  ADDR_W+1  RX frame length in bytes, CRC bytes included.
- `o_rx_done`  out  1  one-cycle pulse, RX operation finished.
- `o_rx_ok`  out  1  CRC residue was 0x0000; valid with `o_rx_done`, held until next RX done.
- `i_tx_req`  in  1  TX generate request; level, held until `o_tx_done`.
- `i_tx_len`  in  ADDR_W+1  TX payload length in bytes, no CRC.
- `o_tx_done`  out  1  one-cycle pulse, TX operation finished.
- `o_tx_crc`  out  16  generated CRC; low byte is sent first. Held until next TX done.
- `o_err`  out  1  pulse with either done: bad length or engine timeout.
- `o_buf_sel`  out  1  0 = RX buffer, 1 = TX buffer.
- `o_buf_rd`  out  1  buffer read strobe.
- `o_buf_addr`  out  ADDR_W  byte address.
- `i_buf_data`  in  8  read data, valid the cycle after `o_buf_rd`.
- `o_crc_clear`  out  1  drives the engine's synchronous active-high reset.
- `o_crc_enable`  out  1  engine enable; 1 whenever out of reset.
- `o_crc_start`, `o_crc_data[7:0]`  out: one-cycle byte start and data to the engine.
- `i_crc_done`, `i_crc16[15:0]`  in: engine done pulse and running CRC.

## Operation
- Reset values: all outputs 0 except `o_crc_clear` = 1. `o_crc_clear` deasserts in the first clock after `i_rst_n` rises. The grant pointer resets to "RX next".
- FSM states: IDLE, CLEAR, READ, WAIT_DATA, FEED, WAIT_CRC, DONE.
- IDLE → CLEAR when any request is pending.
  - The arbiter grants round-robin; on a simultaneous request, the side not served last wins.
  - Grant, side and length are latched; the byte counter is zeroed.
- CLEAR: `o_crc_clear` = 1 for one cycle. This reinitialises the engine to 0xFFFF.
- READ: `o_buf_rd` = 1, `o_buf_addr` = counter.
- WAIT_DATA: capture `i_buf_data`.
- FEED: `o_crc_start` = 1 and `o_crc_data` = captured byte, for one cycle.
- WAIT_CRC: wait for `i_crc_done`.
  - On done, increment the counter. If counter = length, go to DONE; else go to READ.
  - A timeout counter starts at FEED. Reaching `TIMEOUT` → DONE with error.
- DONE:
  - RX: `o_rx_ok` = (`i_crc16` == 0x0000). The frame is checked by feeding all bytes, CRC included; a valid residue is zero.
  - TX: `o_tx_crc` = `i_crc16`.
  - Pulse the granted side's done (plus `o_err` if set), update the grant pointer, return to IDLE.
- Length rules:
  - RX requires length ≥ 3 (at least one payload byte plus two CRC bytes). TX requires ≥ 1. Length must be ≤ 2^ADDR_W.
  - A violation goes IDLE → DONE directly: no buffer reads, no engine activity. It sets `o_err` = 1, and for RX also `o_rx_ok` = 0.
- On timeout: `o_err` = 1, `o_rx_ok` = 0; `o_tx_crc` is loaded with the current `i_crc16` value.
- A request that drops mid-operation is ignored; the operation completes and pulses done.
- A request still high in the cycle after its done pulse is treated as a new request.
- Asynchronous reset mid-operation aborts immediately to reset values. No done pulse is issued.

## Timing
- Request sampled high in IDLE at cycle c. CLEAR is at c+1 and the first READ at c+2.
- With the current engine, `i_crc_done` arrives 11 cycles after FEED. Each byte therefore costs 14 cycles (READ, WAIT_DATA, FEED, 11 × WAIT_CRC).
- The done pulse occurs at cycle c+2+14·len.
- Length error: done pulse at c+1.
- Back-to-back: the next grant can be sampled in the IDLE cycle that follows DONE.

## Structure
- Shared package `modbus_pkg` holds:
  - FSM state typedef
  - `MODBUS_CRC_INIT` = 16'hFFFF
  - `MODBUS_CRC_POLY` = 16'hA001
  - `MODBUS_CRC_RESIDUE` = 16'h0000
  - `RX_MIN_LEN` = 3
- One sub-module, `modbus_crc_arb`: the 2-requester round-robin arbiter with its last-grant register.
- The `Modbus_CRC16` instance lives in the parent, not inside this block.

## Test plan
- TX with len = 6 and bytes 01 03 00 00 00 01 → `o_tx_done` at c+86, `o_tx_crc` = 0x0A84, `o_err` = 0; exactly 6 `o_buf_rd` pulses, addresses 0..5.
- RX with len = 8 and bytes 01 03 00 00 00 01 84 0A → `o_rx_ok` = 1, `o_err` = 0. The same frame with the last byte changed to 0B → `o_rx_ok` = 0.
- `i_rx_req` and `i_tx_req` rise in the same cycle, twice in a row after reset → RX served first, then TX. On the next simultaneous pair, TX is served first.
- RX with len = 2, then TX with len = 0 → each gets done plus `o_err` one cycle after CLEAR-equivalent (c+1), with no `o_buf_rd` and no `o_crc_start`.
- Engine `i_crc_done` tied low → DONE at FEED + 31 with `o_err` = 1; the FSM returns to IDLE.
- Assert `i_rst_n` low during byte 3 of a TX → all outputs at reset values immediately, `o_crc_clear` = 1. After release, a new TX with len = 6 yields 0x0A84.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU CRC sequencing logic: FSM state
// encoding and the CRC-16/MODBUS constants.
package modbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_READ,
      ST_WAIT_DATA,
      ST_FEED,
      ST_WAIT_CRC,
      ST_DONE
   } seq_state_t;

   localparam logic [15:0] MODBUS_CRC_INIT    = 16'hFFFF;
   localparam logic [15:0] MODBUS_CRC_POLY    = 16'hA001;
   localparam logic [15:0] MODBUS_CRC_RESIDUE = 16'h0000;

   // Smallest RX frame: one payload byte plus the two CRC bytes.
   localparam int RX_MIN_LEN = 3;

endpackage

// File: rtl/modbus_crc_arb.sv
// Two-requester round-robin arbiter. On a simultaneous request the side that
// was not served last wins; after reset RX is preferred.
module modbus_crc_arb (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_req,
   input  logic tx_req,
   input  logic update,
   input  logic served_tx,
   output logic valid,
   output logic grant_tx
);

   logic last_tx_q;

   assign valid    = rx_req | tx_req;
   assign grant_tx = tx_req & (~rx_req | ~last_tx_q);

   // Remember which side finished last; reset value makes RX go first.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         last_tx_q <= 1'b1;
      end else if (update) begin
         last_tx_q <= served_tx;
      end
   end

endmodule

// File: rtl/modbus_crc_sequencer.sv
// Walks whole Modbus RTU frames through the shared byte-serial CRC engine.
// RX frames are checked (residue must be zero), TX payloads get a CRC.
module modbus_crc_sequencer
   import modbus_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 31
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rx_req,
   input  logic [ADDR_W:0]   i_rx_len,
   output logic              o_rx_done,
   output logic              o_rx_ok,
   input  logic              i_tx_req,
   input  logic [ADDR_W:0]   i_tx_len,
   output logic              o_tx_done,
   output logic [15:0]       o_tx_crc,
   output logic              o_err,
   output logic              o_buf_sel,
   output logic              o_buf_rd,
   output logic [ADDR_W-1:0] o_buf_addr,
   input  logic [7:0]        i_buf_data,
   output logic              o_crc_clear,
   output logic              o_crc_enable,
   output logic              o_crc_start,
   output logic [7:0]        o_crc_data,
   input  logic              i_crc_done,
   input  logic [15:0]       i_crc16
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [LEN_W-1:0] RX_MIN  = LEN_W'(RX_MIN_LEN);

   seq_state_t       state, next_state;
   logic             side_q;        // 1 = TX operation in progress
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic [7:0]       byte_q;
   logic [TMO_W-1:0] tcnt_q;
   logic             err_q;
   logic             rx_ok_q;
   logic [15:0]      tx_crc_q;
   logic             clear_q;
   logic             enable_q;

   logic             arb_valid;
   logic             arb_grant_tx;
   logic [LEN_W-1:0] req_len;
   logic [LEN_W-1:0] min_len;
   logic             len_bad;
   logic             last_byte;
   logic             tmo_hit;

   modbus_crc_arb u_arb (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .rx_req    (i_rx_req),
      .tx_req    (i_tx_req),
      .update    (state == ST_DONE),
      .served_tx (side_q),
      .valid     (arb_valid),
      .grant_tx  (arb_grant_tx)
   );

   assign last_byte = (cnt_q + LEN_W'(1)) == len_q;
   assign tmo_hit   = tcnt_q == TMO_W'(TIMEOUT - 1);

   // Length of the granted request and whether it is out of range.
   always_comb begin
      req_len = arb_grant_tx ? i_tx_len : i_rx_len;
      min_len = arb_grant_tx ? LEN_W'(1) : RX_MIN;
      len_bad = (req_len < min_len) || (req_len > MAX_LEN);
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one byte is read, fed and awaited per loop.
   always_comb begin
      // NOTE: default assignment first so no path leaves next_state
      // unassigned, which would otherwise infer a latch.
      next_state = state;
      unique case (state)
         ST_IDLE:      if (arb_valid) next_state = len_bad ? ST_DONE : ST_CLEAR;
         ST_CLEAR:     next_state = ST_READ;
         ST_READ:      next_state = ST_WAIT_DATA;
         ST_WAIT_DATA: next_state = ST_FEED;
         ST_FEED:      next_state = ST_WAIT_CRC;
         ST_WAIT_CRC: begin
            if (i_crc_done)   next_state = last_byte ? ST_DONE : ST_READ;
            else if (tmo_hit) next_state = ST_DONE;
         end
         ST_DONE:      next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   // Operation context, byte counter, timeout counter and held results.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         side_q   <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         byte_q   <= '0;
         tcnt_q   <= '0;
         err_q    <= 1'b0;
         rx_ok_q  <= 1'b0;
         tx_crc_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  side_q <= arb_grant_tx;
                  len_q  <= req_len;
                  cnt_q  <= '0;
                  err_q  <= len_bad;
                  if (len_bad && !arb_grant_tx) rx_ok_q <= 1'b0;
               end
            end
            ST_WAIT_DATA: byte_q <= i_buf_data;
            ST_FEED:      tcnt_q <= TMO_W'(1);
            ST_WAIT_CRC: begin
               tcnt_q <= tcnt_q + TMO_W'(1);
               if (i_crc_done) begin
                  cnt_q <= cnt_q + LEN_W'(1);
                  if (last_byte) begin
                     if (side_q) tx_crc_q <= i_crc16;
                     else        rx_ok_q  <= (i_crc16 == MODBUS_CRC_RESIDUE);
                  end
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
                  if (side_q) tx_crc_q <= i_crc16;
                  else        rx_ok_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Engine clear is registered so it is high throughout reset and CLEAR.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clear_q  <= 1'b1;
         enable_q <= 1'b0;
      end else begin
         clear_q  <= (next_state == ST_CLEAR);
         enable_q <= 1'b1;
      end
   end

   assign o_crc_clear  = clear_q;
   assign o_crc_enable = enable_q;
   assign o_buf_sel    = side_q;
   assign o_rx_ok      = rx_ok_q;
   assign o_tx_crc     = tx_crc_q;

   // Per-state strobes towards the buffers, the engine and the requesters.
   always_comb begin
      o_buf_rd    = 1'b0;
      o_buf_addr  = '0;
      o_crc_start = 1'b0;
      o_crc_data  = '0;
      o_rx_done   = 1'b0;
      o_tx_done   = 1'b0;
      o_err       = 1'b0;
      unique case (state)
         ST_READ: begin
            o_buf_rd   = 1'b1;
            o_buf_addr = cnt_q[ADDR_W-1:0];
         end
         ST_FEED: begin
            o_crc_start = 1'b1;
            o_crc_data  = byte_q;
         end
         ST_DONE: begin
            o_rx_done = ~side_q;
            o_tx_done = side_q;
            o_err     = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_modbus_crc_sequencer.sv
// Directed bench for modbus_crc_sequencer with frame-buffer and CRC engine
// models and a scoreboard of expected per-operation results.
module tb_modbus_crc_sequencer;
   import modbus_pkg::*;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              rx_req, tx_req;
   logic [ADDR_W:0]   rx_len, tx_len;
   logic              rx_done, rx_ok, tx_done, err;
   logic [15:0]       tx_crc;
   logic              buf_sel, buf_rd;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_data;
   logic              crc_clear, crc_enable, crc_start, crc_done;
   logic [7:0]        crc_data;
   logic [15:0]       crc16;

   always #5 clk = ~clk;

   modbus_crc_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(31)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_rx_req     (rx_req),
      .i_rx_len     (rx_len),
      .o_rx_done    (rx_done),
      .o_rx_ok      (rx_ok),
      .i_tx_req     (tx_req),
      .i_tx_len     (tx_len),
      .o_tx_done    (tx_done),
      .o_tx_crc     (tx_crc),
      .o_err        (err),
      .o_buf_sel    (buf_sel),
      .o_buf_rd     (buf_rd),
      .o_buf_addr   (buf_addr),
      .i_buf_data   (buf_data),
      .o_crc_clear  (crc_clear),
      .o_crc_enable (crc_enable),
      .o_crc_start  (crc_start),
      .o_crc_data   (crc_data),
      .i_crc_done   (crc_done),
      .i_crc16      (crc16)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame buffers: registered read, data valid the cycle after the strobe.
   logic [7:0] rx_mem [256];
   logic [7:0] tx_mem [256];
   always @(posedge clk) begin
      if (buf_rd) buf_data <= buf_sel ? tx_mem[buf_addr] : rx_mem[buf_addr];
   end

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ MODBUS_CRC_POLY) : (r >> 1);
      return r;
   endfunction

   // CRC engine model: done pulses 11 cycles after start; optional stuck-done.
   logic       tie_low = 1'b0;
   logic       eng_busy = 1'b0;
   logic [3:0] eng_cnt = '0;
   logic [15:0] eng_crc = MODBUS_CRC_INIT;
   always @(posedge clk) begin
      if (crc_clear) begin
         eng_crc  <= MODBUS_CRC_INIT;
         eng_busy <= 1'b0;
         eng_cnt  <= '0;
      end else if (crc_start) begin
         eng_crc  <= crc_byte(eng_crc, crc_data);
         eng_busy <= 1'b1;
         eng_cnt  <= 4'd10;
      end else if (eng_busy) begin
         if (eng_cnt == 0) eng_busy <= 1'b0;
         else              eng_cnt  <= eng_cnt - 4'd1;
      end
   end
   assign crc_done = eng_busy && (eng_cnt == 0) && !tie_low;
   assign crc16    = eng_crc;

   typedef struct {
      bit          tx;
      bit          err;
      bit          ok;
      logic [15:0] crc;
      bit          chk_crc;
      int          cycle;
      int          nbytes;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rd_cnt = 0;
   int   start_cnt = 0;
   bit   seen_rx, seen_tx;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic expect_op(input bit tx, input bit e_err, input bit ok, input logic [15:0] crc,
                            input bit chk_crc, input int cycle, input int nbytes);
      exp_t e;
      e.tx = tx; e.err = e_err; e.ok = ok; e.crc = crc;
      e.chk_crc = chk_crc; e.cycle = cycle; e.nbytes = nbytes;
      sb.push_back(e);
   endtask

   // Observe the DUT at the falling edge and score any completed operation.
   task automatic monitor();
      exp_t e;
      seen_rx = 1'b0;
      seen_tx = 1'b0;
      if (buf_rd) begin
         if (sb.size() == 0) check("rd_without_request", buf_rd, 0);
         else begin
            check("buf_sel", buf_sel, sb[0].tx);
            check("buf_addr", buf_addr, rd_cnt);
         end
         rd_cnt++;
      end
      if (crc_start) begin
         if (sb.size() == 0) check("start_without_request", crc_start, 0);
         else check("crc_data", crc_data, sb[0].tx ? tx_mem[start_cnt] : rx_mem[start_cnt]);
         start_cnt++;
      end
      if (rx_done || tx_done) begin
         seen_rx = rx_done;
         seen_tx = tx_done;
         if (sb.size() == 0) check("done_without_request", {rx_done, tx_done}, 0);
         else begin
            e = sb.pop_front();
            check("done_side", {rx_done, tx_done}, e.tx ? 2'b01 : 2'b10);
            check("done_cycle", cyc, e.cycle);
            check("err", err, e.err);
            check("rd_count", rd_cnt, e.nbytes);
            check("start_count", start_cnt, e.nbytes);
            if (!e.tx)          check("rx_ok", rx_ok, e.ok);
            else if (e.chk_crc) check("tx_crc", tx_crc, e.crc);
         end
         rd_cnt = 0;
         start_cnt = 0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
   endtask

   task automatic raise(input bit do_rx, input bit do_tx, input int rlen, input int tlen, output int c);
      step();
      c = cyc;
      if (do_rx) begin rx_len = 9'(rlen); rx_req = 1'b1; end
      if (do_tx) begin tx_len = 9'(tlen); tx_req = 1'b1; end
   endtask

   // Step until a done pulse; the served side's request drops right after.
   task automatic wait_done(input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         step();
         got = seen_rx | seen_tx;
         if (seen_rx) rx_req = 1'b0;
         if (seen_tx) tx_req = 1'b0;
      end
      if (!got) check("done_timeout", got, 1);
   endtask

   initial begin
      logic [7:0] frame [8];
      int c;
      frame = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
      for (int i = 0; i < 256; i++) begin
         rx_mem[i] = 8'h00;
         tx_mem[i] = 8'h00;
      end
      for (int i = 0; i < 8; i++) rx_mem[i] = frame[i];
      for (int i = 0; i < 6; i++) tx_mem[i] = frame[i];
      rx_req = 1'b0; tx_req = 1'b0; rx_len = '0; tx_len = '0;

      // Reset values.
      #2 rst_n = 1'b0;
      repeat (3) step();
      check("rst_ctrl", {rx_done, tx_done, err, buf_rd, buf_sel, crc_start, crc_enable, crc_clear}, 8'b0000_0001);
      check("rst_data", {rx_ok, tx_crc, buf_addr, crc_data}, 0);
      rst_n = 1'b1;
      step();
      check("clear_release", {crc_clear, crc_enable}, 2'b01);

      // Simultaneous requests after reset: RX first, then TX.
      raise(1, 1, 8, 6, c);
      expect_op(0, 0, 1, 16'h0, 0, c + 2 + 14 * 8, 8);
      expect_op(1, 0, 0, 16'h0A84, 1, c + 2 + 14 * 8 + 1 + 2 + 14 * 6, 6);
      wait_done(300);
      wait_done(300);

      // Corrupted CRC byte: frame rejected.
      rx_mem[7] = 8'h0B;
      raise(1, 0, 8, 0, c);
      expect_op(0, 0, 0, 16'h0, 0, c + 2 + 14 * 8, 8);
      wait_done(300);
      rx_mem[7] = 8'h0A;

      // RX served last, so a simultaneous pair now goes to TX first.
      raise(1, 1, 8, 6, c);
      expect_op(1, 0, 0, 16'h0A84, 1, c + 2 + 14 * 6, 6);
      expect_op(0, 0, 1, 16'h0, 0, c + 2 + 14 * 6 + 1 + 2 + 14 * 8, 8);
      wait_done(300);
      wait_done(300);

      // Length violations: done plus error one cycle after the request.
      raise(1, 0, 2, 0, c);
      expect_op(0, 1, 0, 16'h0, 0, c + 1, 0);
      wait_done(20);
      raise(0, 1, 0, 0, c);
      expect_op(1, 1, 0, 16'h0, 0, c + 1, 0);
      wait_done(20);
      raise(1, 0, 257, 0, c);
      expect_op(0, 1, 0, 16'h0, 0, c + 1, 0);
      wait_done(20);
      raise(0, 1, 0, 257, c);
      expect_op(1, 1, 0, 16'h0, 0, c + 1, 0);
      wait_done(20);

      // Shortest legal lengths.
      raise(1, 0, 3, 0, c);
      expect_op(0, 0, 0, 16'h0, 0, c + 2 + 14 * 3, 3);
      wait_done(100);
      raise(0, 1, 0, 1, c);
      expect_op(1, 0, 0, crc_byte(MODBUS_CRC_INIT, tx_mem[0]), 1, c + 2 + 14, 1);
      wait_done(100);

      // Engine never answers: timeout 31 cycles after FEED.
      tie_low = 1'b1;
      raise(0, 1, 0, 6, c);
      expect_op(1, 1, 0, 16'h0, 0, c + 4 + 31, 1);
      wait_done(100);
      tie_low = 1'b0;

      // Reset during the third byte of a TX aborts without a done pulse.
      raise(0, 1, 0, 6, c);
      expect_op(1, 0, 0, 16'h0A84, 1, 0, 6);
      for (int i = 0; i < 100 && rd_cnt < 3; i++) step();
      check("reached_byte3", rd_cnt, 3);
      rst_n = 1'b0;
      #1;
      check("abort_ctrl", {rx_done, tx_done, err, buf_rd, buf_sel, crc_start, crc_enable, crc_clear}, 8'b0000_0001);
      check("abort_data", {rx_ok, tx_crc, buf_addr, crc_data}, 0);
      tx_req = 1'b0;
      sb.delete();
      rd_cnt = 0;
      start_cnt = 0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("clear_release2", {crc_clear, crc_enable}, 2'b01);
      raise(0, 1, 0, 6, c);
      expect_op(1, 0, 0, 16'h0A84, 1, c + 2 + 14 * 6, 6);
      wait_done(300);

      // No stray activity afterwards.
      repeat (10) step();
      check("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
